// File: rtl/iob_mem_loader_pkg.sv
// Shared types and helpers for the byte-stream memory loader.
// Holds the FSM state encoding and the per-word byte geometry derivations.
package iob_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // A single-byte word still needs a one-bit counter to stay a legal vector.
    function automatic int byte_cnt_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/iob_word_assembler.sv
// Little-endian byte-lane assembler: byte k of a word lands in bits [8k+7:8k].
// word_full_o flags that the next loaded byte completes the current word.
module iob_word_assembler
    import iob_mem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_full_o
);

    localparam int NB = bytes_per_word(DATA_W);
    localparam int CW = byte_cnt_w(NB);

    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;
    logic              last_s;

    assign last_s      = (cnt_q == CW'(NB - 1));
    assign word_full_o = last_s;
    assign word_o      = word_q;

    // Next-state for lane counter and assembly register; clear wins over load.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (load_i) begin
            for (int k = 0; k < NB; k++) begin
                if (cnt_q == CW'(k)) begin
                    word_d[8*k +: 8] = byte_i;
                end else begin
                    word_d[8*k +: 8] = word_q[8*k +: 8];
                end
            end
            cnt_d = last_s ? '0 : cnt_q + CW'(1);
        end else begin
            cnt_d  = cnt_q;
            word_d = word_q;
        end
    end

    // Lane counter and assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/iob_mem_loader.sv
// Byte-stream loader: assembles little-endian words and writes them to a memory
// write port at consecutive (wrapping) addresses starting from a latched base.
module iob_mem_loader
    import iob_mem_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              busy,
    output logic              done
);

    localparam int LW = ADDR_W + 1;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [LW-1:0]     wcnt_q;
    logic [LW-1:0]     wcnt_d;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     len_d;

    logic              start_ok_s;
    logic              accept_s;
    logic              asm_clr_s;
    logic              word_full_s;
    logic [DATA_W-1:0] word_s;

    assign start_ok_s = (state_q == ST_IDLE) && start && !abort;
    assign accept_s   = (state_q == ST_COLLECT) && byte_valid;
    assign asm_clr_s  = start_ok_s || abort;

    iob_word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (asm_clr_s),
        .load_i      (accept_s),
        .byte_i      (byte_data),
        .word_o      (word_s),
        .word_full_o (word_full_s)
    );

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign byte_ready = (state_q == ST_COLLECT);
    assign w_en       = (state_q == ST_WRITE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign w_addr     = addr_q;
    assign w_data     = word_s;

    // FSM next-state plus address/word-count bookkeeping; abort overrides all.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_d  = base_addr;
                        len_d   = len;
                        wcnt_d  = '0;
                        state_d = (len == '0) ? ST_DONE : ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (accept_s && word_full_s) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_WRITE: begin
                    addr_d = addr_q + ADDR_W'(1);
                    wcnt_d = wcnt_q + LW'(1);
                    if (wcnt_d == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, address, word-count and length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_iob_mem_loader.sv
// Directed self-checking bench for iob_mem_loader (DATA_W=32, ADDR_W=11).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_iob_mem_loader;

    localparam int DW = 32;
    localparam int AW = 11;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic [AW-1:0] base_addr  = '0;
    logic [AW:0]   len        = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data  = '0;
    logic          byte_ready;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          busy;
    logic          done;

    iob_mem_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] wa_log [16];
    logic [DW-1:0] wd_log [16];
    int            wc_log [16];
    int            n_w      = 0;
    int            n_done   = 0;
    int            done_cyc = 0;
    int            n_ready  = 0;
    logic [7:0]    bq [16];

    // Write-port / done / ready monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_en && n_w < 16) begin
                wa_log[n_w] = w_addr;
                wd_log[n_w] = w_data;
                wc_log[n_w] = cyc;
                n_w++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (byte_ready) n_ready++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_log();
        n_w = 0; n_done = 0; n_ready = 0; done_cyc = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l, output int s_cyc);
        start = 1'b1; base_addr = b; len = l; s_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input int n, input bit gaps);
        int i = 0;
        int guard = 0;
        bit gap = 1'b0;
        while (i < n && guard < 200) begin
            start = 1'b0;
            if (gap) begin
                byte_valid = 1'b0;
                gap = 1'b0;
                start = 1'b1;
                base_addr = 11'h155;
                len = 12'd7;
            end else begin
                byte_valid = 1'b1;
                byte_data = bq[i];
                if (byte_ready) begin
                    i++;
                    gap = gaps;
                end
            end
            @(negedge clk);
            guard++;
        end
        byte_valid = 1'b0;
        start = 1'b0;
        if (guard >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: accepted %0d of %0d bytes", i, n);
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (n_done == 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({byte_ready, w_en, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 0000", {byte_ready, w_en, busy, done});
        end
        n_tests++;
        if (w_addr !== 11'h000) begin n_fail++; $display("FAIL reset_waddr got %h exp 000", w_addr); end
        n_tests++;
        if (w_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", w_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input bit gaps);
        int s;
        clear_log();
        for (int k = 0; k < 8; k++) bq[k] = 8'(8'h11 * (k + 1));
        do_start(11'h010, 12'd2, s);
        n_tests++;
        if ({busy, byte_ready} !== 2'b11) begin
            n_fail++; $display("FAIL start_busy gaps=%0d got %b exp 11", gaps, {busy, byte_ready});
        end
        push(8, gaps);
        wait_done();
        n_tests++;
        if (n_w !== 2) begin n_fail++; $display("FAIL basic_nw gaps=%0d got %0d exp 2", gaps, n_w); end
        n_tests++;
        if (wa_log[0] !== 11'h010 || wd_log[0] !== 32'h44332211) begin
            n_fail++; $display("FAIL basic_w0 gaps=%0d got %h@%h exp 44332211@010", gaps, wd_log[0], wa_log[0]);
        end
        n_tests++;
        if (wa_log[1] !== 11'h011 || wd_log[1] !== 32'h88776655) begin
            n_fail++; $display("FAIL basic_w1 gaps=%0d got %h@%h exp 88776655@011", gaps, wd_log[1], wa_log[1]);
        end
        n_tests++;
        if (n_done !== 1) begin n_fail++; $display("FAIL basic_ndone gaps=%0d got %0d exp 1", gaps, n_done); end
        n_tests++;
        if (done_cyc - wc_log[1] !== 1) begin
            n_fail++; $display("FAIL basic_done_lat gaps=%0d got %0d exp 1", gaps, done_cyc - wc_log[1]);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle gaps=%0d busy got %b exp 0", gaps, busy); end
        if (!gaps) begin
            n_tests++;
            if (wc_log[0] - s !== 4) begin n_fail++; $display("FAIL basic_w0_lat got %0d exp 4", wc_log[0] - s); end
            n_tests++;
            if (done_cyc - s !== 10) begin n_fail++; $display("FAIL basic_start_done got %0d exp 10", done_cyc - s); end
        end
    endtask

    task automatic test_wrap();
        int s;
        clear_log();
        for (int k = 0; k < 8; k++) bq[k] = 8'(8'hA0 + k);
        do_start(11'h7FF, 12'd2, s);
        push(8, 1'b0);
        wait_done();
        n_tests++;
        if (n_w !== 2 || wa_log[0] !== 11'h7FF || wa_log[1] !== 11'h000) begin
            n_fail++; $display("FAIL wrap_addr got n=%0d %h,%h exp 2 7ff,000", n_w, wa_log[0], wa_log[1]);
        end
        n_tests++;
        if (wd_log[0] !== 32'hA3A2A1A0 || wd_log[1] !== 32'hA7A6A5A4) begin
            n_fail++; $display("FAIL wrap_data got %h,%h exp a3a2a1a0,a7a6a5a4", wd_log[0], wd_log[1]);
        end
    endtask

    task automatic test_len0();
        int s;
        clear_log();
        do_start(11'h040, 12'd0, s);
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done got %b exp 1", done); end
        repeat (5) @(negedge clk);
        n_tests++;
        if (n_w !== 0 || n_ready !== 0) begin
            n_fail++; $display("FAIL len0_quiet got w=%0d ready=%0d exp 0,0", n_w, n_ready);
        end
        n_tests++;
        if (n_done !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL len0_end got done=%0d busy=%b exp 1,0", n_done, busy);
        end
    endtask

    task automatic test_abort();
        int s;
        clear_log();
        bq[0] = 8'h01; bq[1] = 8'h02;
        do_start(11'h020, 12'd2, s);
        push(2, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if ({busy, byte_ready} !== 2'b00) begin
            n_fail++; $display("FAIL abort_idle got %b exp 00", {busy, byte_ready});
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (n_w !== 0 || n_done !== 0) begin
            n_fail++; $display("FAIL abort_quiet got w=%0d done=%0d exp 0,0", n_w, n_done);
        end
        abort = 1'b1; start = 1'b1; base_addr = 11'h070; len = 12'd1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_idle busy got %b exp 0", busy); end
        clear_log();
        bq[0] = 8'hEF; bq[1] = 8'hBE; bq[2] = 8'hAD; bq[3] = 8'hDE;
        do_start(11'h030, 12'd1, s);
        push(4, 1'b0);
        wait_done();
        n_tests++;
        if (n_w !== 1 || wa_log[0] !== 11'h030 || wd_log[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL abort_reload got n=%0d %h@%h exp 1 deadbeef@030", n_w, wd_log[0], wa_log[0]);
        end
    endtask

    task automatic test_async_reset();
        int s;
        clear_log();
        bq[0] = 8'hA1; bq[1] = 8'hA2;
        do_start(11'h050, 12'd2, s);
        push(2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({byte_ready, w_en, busy, done} !== 4'b0000) begin
            n_fail++; $display("FAIL areset_ctrl got %b exp 0000", {byte_ready, w_en, busy, done});
        end
        n_tests++;
        if (w_addr !== 11'h000 || w_data !== 32'h0) begin
            n_fail++; $display("FAIL areset_data got %h@%h exp 0@000", w_data, w_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        bq[0] = 8'h01; bq[1] = 8'h02; bq[2] = 8'h03; bq[3] = 8'h04;
        do_start(11'h060, 12'd1, s);
        push(4, 1'b0);
        wait_done();
        n_tests++;
        if (n_w !== 1 || wa_log[0] !== 11'h060 || wd_log[0] !== 32'h04030201) begin
            n_fail++; $display("FAIL areset_reload got n=%0d %h@%h exp 1 04030201@060", n_w, wd_log[0], wa_log[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_wrap();
        test_len0();
        test_basic(1'b1);
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_mem_loader.md
# iob_mem_loader

Write-side companion to the dual-port ROM/RAM blocks: accepts a byte stream over a valid/ready handshake, assembles little-endian words of DATA_W bits, and writes them into a memory write port at consecutive addresses from a programmable base. Used at boot or by a debug/UART bridge to fill program/data memory that is later read through the memory's read ports.

## Interface
- DATA_W, 32, memory word width; multiple of 8
- ADDR_W, 11, memory address width; memory depth 2**ADDR_W
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE from any state
- base_addr  in  ADDR_W  first word address, latched on accepted start
- len  in  ADDR_W+1  number of words to write, latched on accepted start; 0..2**ADDR_W
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  incoming byte
- byte_ready  out  1  loader accepts a byte this cycle
- w_en  out  1  memory write strobe, one cycle per word
- w_addr  out  ADDR_W  memory write address
- w_data  out  DATA_W  memory write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion

## Operation
- NB = DATA_W/8 bytes per word.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: start=1 latches base_addr and len, clears byte and word counters; len=0 -> DONE, else -> COLLECT. start while not in IDLE is ignored.
- COLLECT: byte_ready=1. Byte accepted when byte_valid && byte_ready at a rising edge; byte k (0-based within the word) is stored in bits [8k+7:8k]. On acceptance of byte NB-1 -> WRITE.
- WRITE: byte_ready=0; w_en=1, w_addr=(base+word_cnt) mod 2**ADDR_W, w_data=assembled word. word_cnt increments; if new word_cnt==len -> DONE, else -> COLLECT.
- DONE: done=1 for exactly one cycle -> IDLE.
- Address wrap: base+word_cnt past 2**ADDR_W-1 wraps to 0; no error flagged.
- abort=1 has priority over every transition: next state IDLE, partial word discarded, no w_en and no done in the following cycle. abort in IDLE has no effect; abort and start in the same IDLE cycle: start is ignored.
- Bytes presented while byte_ready=0 are not consumed; the upstream holds them.
- Reset (any time, mid-word included): state IDLE, counters and assembly register cleared, partial word discarded.
- Reset values: byte_ready=0, w_en=0, w_addr=0, w_data=0, busy=0, done=0.

## Timing
- All outputs registered or decoded from registered state only; no combinational path from byte_valid, start or abort to any output.
- start accepted at edge t0 -> busy and byte_ready high from cycle after t0.
- Last byte of a word accepted at edge t -> w_en high in the cycle after t, for one cycle.
- Sustained throughput with byte_valid held high: one word per NB+1 cycles.
- Final write at cycle c -> done high at cycle c+1, busy low from c+2.
- len=0: start at t0 -> done in cycle after t0, no w_en.

## Structure
- Package iob_mem_loader_pkg: state encoding localparams (IDLE, COLLECT, WRITE, DONE), NB derivation, byte-counter width clog2(NB).
- One sub-module iob_word_assembler: byte-lane register with byte counter, load/clear inputs, word_full flag; top holds FSM, address and word counters.

## Test plan
- Reset then DATA_W=32, base=0x010, len=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 back-to-back -> writes 0x44332211@0x010 and 0x88776655@0x011, done pulse 1 cycle after second w_en, 10 cycles start-to-done.
- base=0x7FF, len=2 (ADDR_W=11) -> writes at 0x7FF then 0x000.
- len=0 -> done one cycle after start, w_en never asserted, byte_ready never high.
- Random byte_valid gaps and start pulses during busy -> identical write contents as gap-free run; extra starts ignored.
- abort after 2 bytes of word 1 -> no w_en, no done, back to IDLE; new load of len=1 with 0xDEADBEEF bytes writes 0xDEADBEEF.
- rst_n low mid-word during load -> all outputs 0 asynchronously; after release fresh load writes correct data with no stale bytes.
